// File: rtl/traffic_pkg.sv
// Shared types and constants for the main/country road traffic-light sequencer.
package traffic_pkg;

    // Width of the seconds-remaining field driven to the countdown display.
    localparam int unsigned SEC_W = 5;

    // Phase encoding kept as plain 2-bit constants for compatibility with legacy users.
    typedef logic [1:0] state_t;
    localparam state_t ST_MG = 2'd0;
    localparam state_t ST_MY = 2'd1;
    localparam state_t ST_CG = 2'd2;
    localparam state_t ST_CY = 2'd3;

    // Lamp patterns, {R,Y,G}.
    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    // Everything that is decoded from the phase and registered alongside it.
    typedef struct packed {
        logic [2:0] main_l;
        logic [2:0] country_l;
        logic       cm;
        logic       cc;
    } lamps_t;

    // Phase -> lamp/indicator decode; unknown phases show the main-green pattern.
    function automatic lamps_t lamps_for(input state_t s);
        lamps_t l;
        case (s)
            ST_MY:   l = '{main_l: LAMP_Y, country_l: LAMP_R, cm: 1'b1, cc: 1'b0};
            ST_CG:   l = '{main_l: LAMP_R, country_l: LAMP_G, cm: 1'b0, cc: 1'b1};
            ST_CY:   l = '{main_l: LAMP_R, country_l: LAMP_Y, cm: 1'b0, cc: 1'b1};
            default: l = '{main_l: LAMP_G, country_l: LAMP_R, cm: 1'b1, cc: 1'b0};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Divides clk down to a one-cycle pulse every TICK_DIV cycles.
// tick is the registered pulse; wrap is the combinational "this edge produces
// a tick" enable so downstream state can change on the same edge tick rises.
module sec_tick_gen #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick,
    output logic wrap
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;

    assign wrap = (cnt_q == CNT_MAX);

    // Next count: 0..TICK_DIV-1, wrapping.
    always_comb begin
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end

    // Counter and registered pulse, high for the cycle after the wrap value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= wrap;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/traffic_light_fsm.sv
// Main/country road light sequencer: steps MG -> MY -> CG -> CY once per second,
// counting down the seconds left in each phase for the display stage.
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned T_MG     = 25,
    parameter int unsigned T_CG     = 15,
    parameter int unsigned T_Y      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             car_country,
    output logic [2:0]       main_light,
    output logic [2:0]       country_light,
    output logic [SEC_W-1:0] light_time,
    output logic             cm,
    output logic             cc,
    output logic             tick
);

    localparam logic [SEC_W-1:0] SEC_MG = SEC_W'(T_MG);
    localparam logic [SEC_W-1:0] SEC_CG = SEC_W'(T_CG);
    localparam logic [SEC_W-1:0] SEC_Y  = SEC_W'(T_Y);
    localparam logic [SEC_W-1:0] SEC_1  = SEC_W'(1);

    logic             wrap;
    state_t           state_q;
    state_t           state_d;
    logic [SEC_W-1:0] light_time_q;
    logic [SEC_W-1:0] light_time_d;
    lamps_t           lamps_q;
    lamps_t           lamps_d;

    sec_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick),
        .wrap (wrap)
    );

    // Phase/countdown next state. Updates on the wrap edge so the change is
    // visible in the same cycle the registered tick is high. A zero countdown
    // is an unreachable state and recovers to main green immediately.
    always_comb begin
        state_d      = state_q;
        light_time_d = light_time_q;
        if (light_time_q == '0) begin
            state_d      = ST_MG;
            light_time_d = SEC_MG;
        end else if (wrap) begin
            if (light_time_q != SEC_1) begin
                light_time_d = light_time_q - SEC_1;
            end else begin
                case (state_q)
                    ST_MG: begin
                        if (car_country) begin
                            state_d      = ST_MY;
                            light_time_d = SEC_Y;
                        end else begin
                            light_time_d = SEC_MG;
                        end
                    end
                    ST_MY: begin
                        state_d      = ST_CG;
                        light_time_d = SEC_CG;
                    end
                    ST_CG: begin
                        state_d      = ST_CY;
                        light_time_d = SEC_Y;
                    end
                    ST_CY: begin
                        state_d      = ST_MG;
                        light_time_d = SEC_MG;
                    end
                    default: begin
                        state_d      = ST_MG;
                        light_time_d = SEC_MG;
                    end
                endcase
            end
        end
    end

    // Lamps are decoded from the next phase so they register together with it.
    always_comb begin
        lamps_d = lamps_for(state_d);
    end

    // Phase, countdown and lamp registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_MG;
            light_time_q <= SEC_MG;
            lamps_q      <= lamps_for(ST_MG);
        end else begin
            state_q      <= state_d;
            light_time_q <= light_time_d;
            lamps_q      <= lamps_d;
        end
    end

    assign main_light    = lamps_q.main_l;
    assign country_light = lamps_q.country_l;
    assign cm            = lamps_q.cm;
    assign cc            = lamps_q.cc;
    assign light_time    = light_time_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench for traffic_light_fsm with short timing parameters.
module tb_traffic_light_fsm;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned T_MG     = 6;
    localparam int unsigned T_CG     = 4;
    localparam int unsigned T_Y      = 2;

    localparam int PH_MG = 0;
    localparam int PH_MY = 1;
    localparam int PH_CG = 2;
    localparam int PH_CY = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       car_country = 1'b0;
    logic [2:0] main_light;
    logic [2:0] country_light;
    logic [4:0] light_time;
    logic       cm;
    logic       cc;
    logic       tick;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       car;
        logic [4:0] lt;
        logic [2:0] ml;
        logic [2:0] cl;
        logic       cm;
        logic       cc;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    traffic_light_fsm #(
        .TICK_DIV(TICK_DIV),
        .T_MG    (T_MG),
        .T_CG    (T_CG),
        .T_Y     (T_Y)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .car_country  (car_country),
        .main_light   (main_light),
        .country_light(country_light),
        .light_time   (light_time),
        .cm           (cm),
        .cc           (cc),
        .tick         (tick)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic c, input int lt, input int ph);
        vec_t v;
        v.car = c;
        v.lt  = lt[4:0];
        case (ph)
            PH_MY:   begin v.ml = 3'b010; v.cl = 3'b100; v.cm = 1'b1; v.cc = 1'b0; end
            PH_CG:   begin v.ml = 3'b100; v.cl = 3'b001; v.cm = 1'b0; v.cc = 1'b1; end
            PH_CY:   begin v.ml = 3'b100; v.cl = 3'b010; v.cm = 1'b0; v.cc = 1'b1; end
            default: begin v.ml = 3'b001; v.cl = 3'b100; v.cm = 1'b1; v.cc = 1'b0; end
        endcase
        return v;
    endfunction

    task automatic add_run(input logic c, input int ph, input int first, input int last);
        for (int t = first; t >= last; t--) tbl.push_back(mk(c, t, ph));
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t e);
        chk({tag, ".light_time"}, int'(light_time), int'(e.lt));
        chk({tag, ".main_light"}, int'(main_light), int'(e.ml));
        chk({tag, ".country_light"}, int'(country_light), int'(e.cl));
        chk({tag, ".cm"}, int'(cm), int'(e.cm));
        chk({tag, ".cc"}, int'(cc), int'(e.cc));
    endtask

    // Waits (bounded) for the next tick, sampled on falling edges.
    task automatic wait_tick(output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (tick) seen = 1'b1;
        end
    endtask

    // Drive one row, queue its expectation, and compare at the next tick.
    task automatic step(input vec_t v, input string tag, output int n);
        vec_t e;
        bit   seen;
        car_country = v.car;
        exp_q.push_back(v);
        wait_tick(n, seen);
        chk({tag, ".tick_seen"}, int'(seen), 1);
        e = exp_q.pop_front();
        check_vec(tag, e);
    endtask

    task automatic run_rows(input int lo, input int hi);
        int n;
        for (int i = lo; i <= hi; i++) step(tbl[i], $sformatf("row%0d", i), n);
    endtask

    // Per-cycle invariants and tick width/period.
    int  since = 0;
    bit  have_prev = 1'b0;
    bit  prev_tick = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            since     = 0;
            have_prev = 1'b0;
            prev_tick = 1'b0;
        end else begin
            since++;
            if (tick) begin
                if (have_prev) chk("tick_period", since, TICK_DIV);
                have_prev = 1'b1;
                since     = 0;
            end
            chk("tick_width", int'(prev_tick && tick), 0);
            prev_tick = tick;
            chk("main_onehot", int'($onehot(main_light)), 1);
            chk("country_onehot", int'($onehot(country_light)), 1);
            chk("both_nonred", int'(main_light != 3'b100 && country_light != 3'b100), 0);
            chk("cm_and_cc", int'(cm && cc), 0);
            chk("light_time_nonzero", int'(light_time != 5'd0), 1);
        end
    end

    initial begin
        int   n;
        int   a_lo, a_hi, b_lo, b_hi, c_lo, c_hi, d_lo, d_hi, e_lo, e_hi, f_lo;
        vec_t rst_v;

        rst_v = mk(1'b0, T_MG, PH_MG);

        // A: car waiting, full cycle MG -> MY -> CG -> CY -> MG
        a_lo = tbl.size();
        add_run(1'b1, PH_MG, 4, 1);
        add_run(1'b1, PH_MY, 2, 1);
        add_run(1'b1, PH_CG, 4, 1);
        add_run(1'b1, PH_CY, 2, 1);
        add_run(1'b1, PH_MG, 6, 6);
        a_hi = tbl.size() - 1;
        // B: no car, main green extended
        b_lo = tbl.size();
        add_run(1'b0, PH_MG, 5, 1);
        add_run(1'b0, PH_MG, 6, 6);
        b_hi = tbl.size() - 1;
        // C: after a one-cycle car pulse, still extended
        c_lo = tbl.size();
        add_run(1'b0, PH_MG, 5, 1);
        add_run(1'b0, PH_MG, 6, 6);
        c_hi = tbl.size() - 1;
        // D: car again, run into CG with 3 s left
        d_lo = tbl.size();
        add_run(1'b1, PH_MG, 5, 1);
        add_run(1'b1, PH_MY, 2, 1);
        add_run(1'b1, PH_CG, 4, 3);
        d_hi = tbl.size() - 1;
        // E: after mid-CG reset, back into CG
        e_lo = tbl.size();
        add_run(1'b1, PH_MG, 4, 1);
        add_run(1'b1, PH_MY, 2, 1);
        add_run(1'b1, PH_CG, 4, 4);
        e_hi = tbl.size() - 1;
        // F: first tick after illegal-state recovery
        f_lo = tbl.size();
        add_run(1'b0, PH_MG, 5, 5);

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check_vec("reset", rst_v);
        chk("reset.tick", int'(tick), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        step(mk(1'b1, 5, PH_MG), "first_tick", n);
        chk("first_tick_latency", n, TICK_DIV);

        run_rows(a_lo, a_hi);
        run_rows(b_lo, b_hi);

        // One-cycle car pulse in a non-tick cycle mid-MG
        car_country = 1'b1;
        @(negedge clk);
        car_country = 1'b0;
        chk("pulse.tick", int'(tick), 0);
        check_vec("pulse", mk(1'b0, 6, PH_MG));
        run_rows(c_lo, c_hi);

        run_rows(d_lo, d_hi);

        // Reset for one clock mid-CG (light_time=3)
        #1 rst_n = 1'b0;
        #1;
        check_vec("midcg_reset", rst_v);
        chk("midcg_reset.tick", int'(tick), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step(mk(1'b1, 5, PH_MG), "post_reset_tick", n);
        chk("post_reset_latency", n, TICK_DIV);

        run_rows(e_lo, e_hi);

        // Zero countdown is an illegal state: recover to MG on the next edge
        #2 force dut.light_time_q = 5'd0;
        #1 release dut.light_time_q;
        @(negedge clk);
        chk("illegal.tick", int'(tick), 0);
        check_vec("illegal_recover", mk(1'b0, T_MG, PH_MG));
        run_rows(f_lo, f_lo);

        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
